// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter: three-master round-robin arbiter in front of a single
// AHB-to-APB bridge. It owns the address-phase grant, tracks the data-phase
// owner, and muxes the selected master onto the bridge-side AHB signals.
module ahb_master_arbiter #(
  parameter int MAX_BEATS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  m_req,
  input  logic [95:0] m_Haddr,
  input  logic [5:0]  m_Htrans,
  input  logic [2:0]  m_Hwrite,
  input  logic [95:0] m_Hwdata,
  output logic [2:0]  m_grant,
  output logic [2:0]  m_Hready,
  output logic [31:0] Haddr,
  output logic [1:0]  Htrans,
  output logic        Hwrite,
  output logic [31:0] Hwdata,
  output logic        Hreadyin,
  input  logic        Hreadyout
);

  localparam int            CW      = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);
  localparam logic [1:0]    TR_IDLE = 2'b00;
  localparam logic [1:0]    TR_SEQ  = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [2:0]    grant_r;
  logic [2:0]    grant_nxt_s;
  logic [1:0]    start_r;
  logic [1:0]    start_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic [2:0]    downer_r;
  logic [2:0]    pick_s;
  logic          owner_req_s;
  logic          others_req_s;
  logic          rearb_s;

  // Round-robin pick: first requester found walking upward from 'start'
  // (wrapping 2 -> 0). Returns one-hot, or zero when nobody requests.
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] start);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = 3'b000;
    idx  = (start == 2'd3) ? 2'd0 : start;
    for (int k = 0; k < 3; k++) begin
      pick[idx] = pick[idx] | (req[idx] & ~(|pick));
      idx       = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
    return pick;
  endfunction

  // Search start for the next arbitration: the master after the winner.
  function automatic logic [1:0] next_start(input logic [2:0] onehot);
    logic [1:0] nxt;
    case (onehot)
      3'b001:  nxt = 2'd1;
      3'b010:  nxt = 2'd2;
      3'b100:  nxt = 2'd0;
      default: nxt = 2'd0;
    endcase
    return nxt;
  endfunction

  // Select one 32-bit lane of a packed three-master bus by a one-hot owner.
  function automatic logic [31:0] sel32(input logic [2:0] oh, input logic [95:0] bus);
    logic [31:0] v;
    case (oh)
      3'b001:  v = bus[31:0];
      3'b010:  v = bus[63:32];
      3'b100:  v = bus[95:64];
      default: v = 32'h0000_0000;
    endcase
    return v;
  endfunction

  // Address-phase mux: bridge sees only the granted master, idle otherwise.
  always_comb begin
    Haddr = sel32(grant_r, m_Haddr);
    case (grant_r)
      3'b001: begin
        Htrans = m_Htrans[1:0];
        Hwrite = m_Hwrite[0];
      end
      3'b010: begin
        Htrans = m_Htrans[3:2];
        Hwrite = m_Hwrite[1];
      end
      3'b100: begin
        Htrans = m_Htrans[5:4];
        Hwrite = m_Hwrite[2];
      end
      default: begin
        Htrans = TR_IDLE;
        Hwrite = 1'b0;
      end
    endcase
  end

  // Data-phase mux: write data follows the registered data-phase owner.
  always_comb begin
    Hwdata = sel32(downer_r, m_Hwdata);
  end

  // Ready is a straight broadcast from the bridge.
  always_comb begin
    Hreadyin = Hreadyout;
    m_Hready = {3{Hreadyout}};
  end

  // Owner status used by the re-arbitration decision.
  always_comb begin
    owner_req_s  = |(m_req & grant_r);
    others_req_s = |(m_req & ~grant_r);
    pick_s       = rr_pick(m_req, start_r);
  end

  // Next-state logic: arbitrate only when the bridge accepts the cycle; a
  // SEQ beat from the owner is never interrupted.
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_r;
    start_nxt_s = start_r;
    cnt_nxt_s   = cnt_r;
    rearb_s     = 1'b0;
    if (Hreadyout) begin
      case (state_r)
        ST_IDLE: begin
          if (|m_req) begin
            state_nxt_s = ST_OWNED;
            grant_nxt_s = pick_s;
            start_nxt_s = next_start(pick_s);
            cnt_nxt_s   = {CW{1'b0}};
          end else begin
            state_nxt_s = ST_IDLE;
            grant_nxt_s = 3'b000;
          end
        end
        ST_OWNED: begin
          rearb_s = (Htrans != TR_SEQ) &&
                    (!owner_req_s || (Htrans == TR_IDLE) ||
                     ((cnt_r >= MAX_CNT) && others_req_s));
          if (rearb_s) begin
            cnt_nxt_s = {CW{1'b0}};
            if (|m_req) begin
              state_nxt_s = ST_OWNED;
              grant_nxt_s = pick_s;
              start_nxt_s = next_start(pick_s);
            end else begin
              state_nxt_s = ST_IDLE;
              grant_nxt_s = 3'b000;
            end
          end else if (Htrans[1] && (cnt_r < MAX_CNT)) begin
            cnt_nxt_s = cnt_r + CW'(1);
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          grant_nxt_s = 3'b000;
          cnt_nxt_s   = {CW{1'b0}};
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Arbitration state: FSM, grant, round-robin start and beat counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      grant_r <= 3'b000;
      start_r <= 2'd0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      grant_r <= grant_nxt_s;
      start_r <= start_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Data-phase owner: the address owner moves into its data phase whenever
  // the bridge accepts a cycle, even if its request has since dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      downer_r <= 3'b000;
    end else if (Hreadyout) begin
      downer_r <= grant_r;
    end else begin
      downer_r <= downer_r;
    end
  end

  assign m_grant = grant_r;

endmodule

// File: doc/ahb_master_arbiter.md
AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

Interface
REQ-001 SHALL have parameter MAX_BEATS, default 8: beats an owner may issue before it is pre-empted when another request is pending.
REQ-002 SHALL have port clk, input, 1: the only clock; all state on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port m_req, input, 3: bus request, one bit per master 0..2.
REQ-005 SHALL have port m_Haddr, input, 96: master i address at bits [32i+31:32i].
REQ-006 SHALL have port m_Htrans, input, 6: master i Htrans at bits [2i+1:2i] (00 IDLE, 10 NONSEQ, 11 SEQ).
REQ-007 SHALL have port m_Hwrite, input, 3: master i write flag.
REQ-008 SHALL have port m_Hwdata, input, 96: master i write data.
REQ-009 SHALL have port m_grant, output, 3: one-hot or zero address-phase grant.
REQ-010 SHALL have port m_Hready, output, 3: Hreadyout from the bridge, broadcast to every master.
REQ-011 SHALL have ports Haddr (32), Htrans (2), Hwrite (1), Hwdata (32), Hreadyin (1), all outputs to the AHB-to-APB bridge.
REQ-012 SHALL have port Hreadyout, input, 1: bridge ready.

Function
REQ-013 SHALL use a two-state FSM: IDLE (m_grant=000) and OWNED (exactly one m_grant bit set).
REQ-014 SHALL arbitrate only on a rising edge where Hreadyout=1; when Hreadyout=0, grant, FSM, beat counter and pointer SHALL hold.
REQ-015 SHALL use round-robin: search starts at (last granted index + 1) mod 3; after reset the search starts at master 0.
REQ-016 SHALL move IDLE->OWNED when any m_req bit is set, registering the winner's grant; the grant is visible the following cycle, giving 1-cycle request-to-grant latency.
REQ-017 SHALL re-arbitrate in OWNED when the owner's m_req=0, or its Htrans=IDLE, or (beat count >= MAX_BEATS and another m_req is set and owner Htrans!=SEQ); if no request is pending the FSM SHALL return to IDLE.
REQ-018 SHALL never revoke a grant while the owner drives SEQ; bursts are broken only at NONSEQ/IDLE boundaries.
REQ-019 SHALL count owner beats (Htrans NONSEQ or SEQ accepted with Hreadyout=1), saturating at MAX_BEATS, and clear the count on every grant change.
REQ-020 SHALL drive Haddr, Htrans and Hwrite combinationally from the granted master; with no grant, Haddr=0, Htrans=00 and Hwrite=0.
REQ-021 SHALL register a data-phase owner, loaded with the address owner (or none) on each edge with Hreadyout=1; Hwdata SHALL mux from the data-phase owner, 0 if none.
REQ-022 SHALL drive Hreadyin = Hreadyout and m_Hready = {3{Hreadyout}}.
REQ-023 SHALL let a master whose request drops during its own data phase complete that data phase; Hwdata stays sourced from it for that phase.
REQ-024 SHALL resolve simultaneous requests purely by round-robin order, with no fixed priority beyond the post-reset start point.

Reset
REQ-025 SHALL, while reset=1, force FSM=IDLE, m_grant=000, data owner=none, beat count=0 and round-robin start=master 0, making Haddr=0, Htrans=00, Hwrite=0 and Hwdata=0.
REQ-026 SHALL, on reset asserted mid-burst, drop the grant immediately (asynchronously) with no completion of the outstanding beat.

Verification
REQ-027 SHALL test: m_req=111 at reset release, Hreadyout=1 -> grants 001 then 010 then 100 in successive tenures as each owner drops its request.
REQ-028 SHALL test: master 1 single NONSEQ write to Haddr=0x8000_0004, Hwdata=0xA5A5_A5A5 -> Htrans=10 on the bus the cycle after grant, Hwdata=0xA5A5_A5A5 the next cycle.
REQ-029 SHALL test: master 0 continuous SEQ burst of 12 beats, MAX_BEATS=8, master 2 requesting -> no grant change until master 0 drives NONSEQ/IDLE, then m_grant=100.
REQ-030 SHALL test: Hreadyout held 0 for 3 cycles while m_req changes -> m_grant, Haddr and Hwdata stable throughout.
REQ-031 SHALL test: reset pulsed during the data phase of a master 2 write -> m_grant=000 and Htrans=00 in the same cycle; first post-reset grant goes to master 0 when all request.
